// File: rtl/mips_alu_pkg.sv
// Shared ALU select codes and the MIPS opcode/funct values decoded
// by the issue stage.
package mips_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  typedef enum logic [1:0] {
    A_ZERO, A_RS, A_RT, A_IMMZ
  } a_src_e;

  typedef enum logic [2:0] {
    B_ZERO, B_RT, B_SHAMT, B_IMMS, B_IMMZ, B_K16
  } b_src_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into ALU select and operand pair.
// Unsupported encodings yield ADD of 0,0 with the illegal flag set.
module alu_op_decode
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic [4:0]       i_shamt,
  input  logic [15:0]      i_imm,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic [2:0]       o_sel,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_illegal
);

  logic   w_r;
  logic   w_r_add, w_r_sub, w_r_and, w_r_or, w_r_xor;
  logic   w_r_sll, w_r_srl;
  logic   w_i_add, w_i_br, w_i_and, w_i_or, w_i_xor, w_i_lui;
  a_src_e w_a_src;
  b_src_e w_b_src;

  assign w_r     = (i_opcode == OP_RTYPE);
  assign w_r_add = w_r && (i_funct == FN_ADD || i_funct == FN_ADDU);
  assign w_r_sub = w_r && (i_funct == FN_SUB || i_funct == FN_SUBU);
  assign w_r_and = w_r && (i_funct == FN_AND);
  assign w_r_or  = w_r && (i_funct == FN_OR);
  assign w_r_xor = w_r && (i_funct == FN_XOR);
  assign w_r_sll = w_r && (i_funct == FN_SLL);
  assign w_r_srl = w_r && (i_funct == FN_SRL);

  assign w_i_add = (i_opcode == OP_ADDI) || (i_opcode == OP_ADDIU)
                || (i_opcode == OP_LW)   || (i_opcode == OP_SW);
  assign w_i_br  = (i_opcode == OP_BEQ) || (i_opcode == OP_BNE);
  assign w_i_and = (i_opcode == OP_ANDI);
  assign w_i_or  = (i_opcode == OP_ORI);
  assign w_i_xor = (i_opcode == OP_XORI);
  assign w_i_lui = (i_opcode == OP_LUI);

  always_comb begin
    o_sel     = ALU_ADD;
    w_a_src   = A_ZERO;
    w_b_src   = B_ZERO;
    o_illegal = 1'b0;
    unique case (1'b1)
      w_r_add: begin o_sel = ALU_ADD; w_a_src = A_RS; w_b_src = B_RT; end
      w_r_sub: begin o_sel = ALU_SUB; w_a_src = A_RS; w_b_src = B_RT; end
      w_r_and: begin o_sel = ALU_AND; w_a_src = A_RS; w_b_src = B_RT; end
      w_r_or:  begin o_sel = ALU_OR;  w_a_src = A_RS; w_b_src = B_RT; end
      w_r_xor: begin o_sel = ALU_XOR; w_a_src = A_RS; w_b_src = B_RT; end
      w_r_sll: begin o_sel = ALU_SHL; w_a_src = A_RT; w_b_src = B_SHAMT; end
      w_r_srl: begin o_sel = ALU_SHR; w_a_src = A_RT; w_b_src = B_SHAMT; end
      w_i_add: begin o_sel = ALU_ADD; w_a_src = A_RS; w_b_src = B_IMMS; end
      w_i_br:  begin o_sel = ALU_SUB; w_a_src = A_RS; w_b_src = B_RT; end
      w_i_and: begin o_sel = ALU_AND; w_a_src = A_RS; w_b_src = B_IMMZ; end
      w_i_or:  begin o_sel = ALU_OR;  w_a_src = A_RS; w_b_src = B_IMMZ; end
      w_i_xor: begin o_sel = ALU_XOR; w_a_src = A_RS; w_b_src = B_IMMZ; end
      w_i_lui: begin o_sel = ALU_SHL; w_a_src = A_IMMZ; w_b_src = B_K16; end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_a = '0;
    unique case (w_a_src)
      A_RS:    o_a = i_rs;
      A_RT:    o_a = i_rt;
      A_IMMZ:  o_a = {{(WIDTH-16){1'b0}}, i_imm};
      default: o_a = '0;
    endcase
  end

  always_comb begin
    o_b = '0;
    unique case (w_b_src)
      B_RT:    o_b = i_rt;
      B_SHAMT: o_b = {{(WIDTH-5){1'b0}}, i_shamt};
      B_IMMS:  o_b = {{(WIDTH-16){i_imm[15]}}, i_imm};
      B_IMMZ:  o_b = {{(WIDTH-16){1'b0}}, i_imm};
      B_K16:   o_b = WIDTH'(16);
      default: o_b = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU; flush beats stall beats load,
// and an empty ID slot loads zeros so no stale operands reach EX.
module alu_issue_stage
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [4:0]       id_shamt,
  input  logic [15:0]      id_imm,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [2:0]       ex_alu_sel,
  output logic [WIDTH-1:0] ex_alu_a,
  output logic [WIDTH-1:0] ex_alu_b,
  output logic             ex_illegal
);

  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_illegal;

  logic             r_valid;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_illegal;

  alu_op_decode #(.WIDTH(WIDTH)) u_dec (
    .i_opcode  (id_opcode),
    .i_funct   (id_funct),
    .i_shamt   (id_shamt),
    .i_imm     (id_imm),
    .i_rs      (id_rs_data),
    .i_rt      (id_rt_data),
    .o_sel     (w_sel),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_sel     <= ALU_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_sel     <= ALU_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_valid   <= id_valid;
      r_sel     <= id_valid ? w_sel : ALU_ADD;
      r_a       <= id_valid ? w_a : '0;
      r_b       <= id_valid ? w_b : '0;
      r_illegal <= id_valid & w_illegal;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_alu_sel = r_sel;
  assign ex_alu_a   = r_a;
  assign ex_alu_b   = r_b;
  assign ex_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised scoreboard bench for alu_issue_stage against an
// instruction-level reference model of the ID/EX register.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [15:0] id_imm;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_alu_sel;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic        ex_illegal;

  exp_t q[$];
  exp_t mdl;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_funct   (id_funct),
    .id_shamt   (id_shamt),
    .id_imm     (id_imm),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .stall      (stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_alu_sel (ex_alu_sel),
    .ex_alu_a   (ex_alu_a),
    .ex_alu_b   (ex_alu_b),
    .ex_illegal (ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t op(input logic [2:0] s,
                              input logic [31:0] a,
                              input logic [31:0] b);
    exp_t e;
    e = '0;
    e.v = 1'b1;
    e.sel = s;
    e.a = a;
    e.b = b;
    return e;
  endfunction

  // Instruction semantics: what the ALU must be told for each instruction.
  function automatic exp_t ref_dec(input logic [5:0] opc,
                                   input logic [5:0] fn,
                                   input logic [4:0] sh,
                                   input logic [15:0] imm,
                                   input logic [31:0] rs,
                                   input logic [31:0] rt);
    exp_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = 32'(signed'(imm));
    zx = 32'(imm);
    e = '0;
    e.v = 1'b1;
    e.ill = 1'b1;
    case (opc)
      6'h00: case (fn)
        6'h20, 6'h21: e = op(3'b000, rs, rt);
        6'h22, 6'h23: e = op(3'b010, rs, rt);
        6'h24: e = op(3'b111, rs, rt);
        6'h25: e = op(3'b110, rs, rt);
        6'h26: e = op(3'b100, rs, rt);
        6'h00: e = op(3'b001, rt, 32'(sh));
        6'h02: e = op(3'b101, rt, 32'(sh));
        default: ;
      endcase
      6'h08, 6'h09, 6'h23, 6'h2B: e = op(3'b000, rs, sx);
      6'h04, 6'h05: e = op(3'b010, rs, rt);
      6'h0C: e = op(3'b111, rs, zx);
      6'h0D: e = op(3'b110, rs, zx);
      6'h0E: e = op(3'b100, rs, zx);
      6'h0F: e = op(3'b001, zx, 32'd16);
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st,
                       input logic fl);
    id_valid = v;
    id_opcode = opc;
    id_funct = fn;
    id_shamt = sh;
    id_imm = imm;
    id_rs_data = rs;
    id_rt_data = rt;
    stall = st;
    flush = fl;
    if (fl) mdl = '0;
    else if (!st) mdl = v ? ref_dec(opc, fn, sh, imm, rs, rt) : '0;
    q.push_back(mdl);
    @(negedge clk);
  endtask

  function automatic exp_t got();
    return {ex_valid, ex_alu_sel, ex_alu_a, ex_alu_b, ex_illegal};
  endfunction

  task automatic chk_zero(input string nm);
    n_chk++;
    if (got() !== '0) begin
      n_fail++;
      $display("FAIL %s: got %h expected 0", nm, got());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (got() !== e) begin
        n_fail++;
        $display("FAIL ex_out t=%0t: got v=%b sel=%b a=%h b=%h ill=%b, expected v=%b sel=%b a=%h b=%h ill=%b",
                 $time, ex_valid, ex_alu_sel, ex_alu_a, ex_alu_b, ex_illegal,
                 e.v, e.sel, e.a, e.b, e.ill);
      end
    end
  end

  logic [5:0] legal_ops [11] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B,
                                 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] legal_fns [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                 6'h25, 6'h26, 6'h00, 6'h02};

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    mdl = '0;
    rst_n = 1'b0;
    id_valid = 1'b0;
    id_opcode = 6'h00;
    id_funct = 6'h20;
    id_shamt = '0;
    id_imm = '0;
    id_rs_data = 32'd5;
    id_rt_data = 32'd7;
    stall = 1'b0;
    flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      id_valid = ~id_valid;
      chk_zero("reset");
    end
    rst_n = 1'b1;
    drive(1, 6'h00, 6'h20, 0, 16'h0, 32'd5, 32'd7, 0, 0);
    drive(1, 6'h08, 6'h00, 0, 16'hFFFC, 32'd10, 32'd3, 0, 0);
    drive(1, 6'h0D, 6'h00, 0, 16'hFFFC, 32'd10, 32'd3, 0, 0);
    drive(1, 6'h0F, 6'h00, 0, 16'h1234, 32'd9, 32'd9, 0, 0);
    drive(1, 6'h00, 6'h02, 4, 16'h0, 32'd1, 32'hF0, 0, 0);
    drive(1, 6'h00, 6'h00, 0, 16'h0, 32'd0, 32'hAB, 0, 0);
    drive(1, 6'h00, 6'h2A, 0, 16'h0, 32'd4, 32'd6, 0, 0);
    drive(1, 6'h2A, 6'h20, 0, 16'h5, 32'd4, 32'd6, 1, 0);
    drive(1, 6'h00, 6'h22, 0, 16'h0, 32'd8, 32'd2, 1, 0);
    drive(0, 6'h0E, 6'h00, 0, 16'h77, 32'd8, 32'd2, 1, 0);
    drive(1, 6'h23, 6'h00, 0, 16'h8000, 32'h100, 32'd2, 0, 0);
    drive(1, 6'h04, 6'h00, 0, 16'h0, 32'h11, 32'h22, 1, 1);
    drive(1, 6'h2B, 6'h00, 0, 16'h0010, 32'h40, 32'h0, 0, 0);
    drive(0, 6'h00, 6'h20, 0, 16'h0, 32'h1, 32'h2, 0, 0);
    for (int i = 0; i < 400; i++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom)
          : legal_ops[$urandom_range(0, 10)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom)
          : legal_fns[$urandom_range(0, 8)];
      drive($urandom_range(0, 4) != 0, o, f, 5'($urandom), 16'($urandom),
            $urandom, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
    end
    drive(1, 6'h00, 6'h24, 0, 16'h0, 32'hF0F0, 32'hFF00, 0, 0);
    // Reset lands between edges while stalled: outputs clear at once.
    stall = 1'b1;
    id_valid = 1'b1;
    mdl = '0;
    q.push_back(mdl);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid_stall");
    @(negedge clk);
    q.push_back(mdl);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 6'h00, 6'h20, 0, 16'h0, 32'd5, 32'd7, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
